// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative shift-add multiplier.
// Imported by the operand prep and the multiplier top.
package mul_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W = $clog2(XLEN_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    NEG,
    DONE
  } state_t;

endpackage

// File: rtl/mul_operand_prep.sv
// Operand magnitudes and result sign for a multiply.
// Purely combinational; 0x80..0 maps to unsigned 2^(XLEN-1).
module mul_operand_prep
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            neg
);

  logic a_neg;
  logic b_neg;

  assign a_neg = a_signed & in_a[XLEN-1];
  assign b_neg = b_signed & in_b[XLEN-1];

  assign abs_a = a_neg ? (~in_a + 1'b1) : in_a;
  assign abs_b = b_neg ? (~in_b + 1'b1) : in_b;
  assign neg   = a_neg ^ b_neg;

endmodule

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add multiplier driving an external 2*XLEN adder.
// The same adder accumulates partial products and negates the result.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] out_prod,
  output logic [2*XLEN-1:0] add_a,
  output logic [2*XLEN-1:0] add_b,
  output logic              add_cin,
  input  logic [2*XLEN-1:0] add_sum
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            op_neg;

  mul_operand_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .in_a    (in_a),
    .in_b    (in_b),
    .a_signed(a_signed),
    .b_signed(b_signed),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .neg     (op_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= PW'(abs_a);
            mplier <= abs_b;
            neg    <= op_neg;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc <= add_sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= neg ? NEG : DONE;
          end
        end
        NEG: begin
          acc   <= add_sum;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder operands are decoded straight from state; no register on this path.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state)
      BUSY: begin
        add_a = acc;
        add_b = mplier[cnt] ? (mcand << cnt) : '0;
      end
      NEG: begin
        add_a   = ~acc;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_prod  = acc;

endmodule

// File: tb/tb_mul_shift_add.sv
// Randomized and directed bench for mul_shift_add.
// Models the external adder and checks against plain 64-bit multiply.
module tb_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        a_signed;
  logic        b_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b + 64'(add_cin);

  mul_shift_add #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sa,
                                           input logic sb);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sa ? 64'(signed'(a)) : 64'(a);
    eb = sb ? 64'(signed'(b)) : 64'(b);
    return ea * eb;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input int hold);
    logic [63:0] exp;
    logic        nf;
    int          lat;
    int          cin_n;
    int          negb_bad;
    bit          seen;
    exp      = ref_prod(a, b, sa, sb);
    nf       = (sa & a[31]) ^ (sb & b[31]);
    cin_n    = 0;
    negb_bad = 0;
    seen     = 0;
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    in_a     = a;
    in_b     = b;
    a_signed = sa;
    b_signed = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
      end else begin
        if (add_cin) begin
          cin_n++;
          if (add_b != 64'd0) negb_bad++;
        end
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) begin
      chk("timeout", 64'd0, 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    chk("latency", 64'(lat), nf ? 64'd34 : 64'd33);
    chk("product", out_prod, exp);
    chk("neg_cin", 64'(cin_n), 64'(nf));
    chk("neg_addb", 64'(negb_bad), 64'd0);
    repeat (hold) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_prod", out_prod, exp);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hs_ready", 64'(in_ready), 64'd1);
    chk("hs_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic abort_op(input bit use_rst);
    int vcnt;
    vcnt = 0;
    @(negedge clk);
    in_a     = 32'hdeadbeef;
    in_b     = 32'h01234567;
    a_signed = 1'b1;
    b_signed = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1 begin
      rst   = 1'b0;
      flush = 1'b0;
    end
    @(negedge clk);
    chk(use_rst ? "rst_ready" : "flush_ready", 64'(in_ready), 64'd1);
    chk(use_rst ? "rst_valid" : "flush_valid", 64'(out_valid), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("abort_no_valid", 64'(vcnt), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod", out_prod, 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_add_b", add_b, 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 0);
    run_op(32'hfffffffd, 32'd5, 1'b1, 1'b1, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 0);
    run_op(32'h80000000, 32'hffffffff, 1'b1, 1'b0, 0);
    run_op(32'hffffffff, 32'hffffffff, 1'b0, 1'b0, 0);
    run_op(32'hffffffff, 32'hffffffff, 1'b1, 1'b1, 5);
    run_op(32'd0, 32'hffffffff, 1'b1, 1'b1, 0);

    abort_op(1'b0);
    abort_op(1'b1);

    for (int i = 0; i < 24; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), (i % 6 == 0) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
